// File: rtl/aes_pkg.sv
// Shared AES-128 round constants and GF(2^8) helpers.
// Byte 0 is the most significant byte; words are column-major.
package aes_pkg;

    localparam int STATE_W    = 128;
    localparam int NUM_ROUNDS = 10;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [STATE_W-1:0] mix_columns(input logic [STATE_W-1:0] s);
        return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
    endfunction

    function automatic logic [7:0] get_byte(input logic [STATE_W-1:0] s, input int unsigned i);
        return s[7'(STATE_W - 8 - 8 * i) +: 8];
    endfunction

    function automatic logic [31:0] get_word(input logic [STATE_W-1:0] s, input int unsigned i);
        return s[7'(STATE_W - 32 - 32 * i) +: 32];
    endfunction

    function automatic logic rnd_ok(input int unsigned rnd);
        return (rnd >= 1) && (rnd <= NUM_ROUNDS);
    endfunction

    function automatic logic [7:0] rcon(input int unsigned rnd);
        case (rnd)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_pipe_if.sv
// Valid/ready stream bundle for one AES round: input transaction and round result.
interface aes_round_pipe_if import aes_pkg::*; #(parameter int RND_W = 4);

    logic               in_valid;
    logic               in_ready;
    logic [RND_W-1:0]   in_rnd;
    logic               in_last;
    logic [STATE_W-1:0] in_prev_rk;
    logic [STATE_W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [RND_W-1:0]   out_rnd;
    logic               out_last;
    logic               out_err;
    logic [STATE_W-1:0] out_rk;
    logic [STATE_W-1:0] out_data;

    modport slave (
        input  in_valid, in_rnd, in_last, in_prev_rk, in_data, out_ready,
        output in_ready, out_valid, out_rnd, out_last, out_err, out_rk, out_data
    );

    modport master (
        output in_valid, in_rnd, in_last, in_prev_rk, in_data, out_ready,
        input  in_ready, out_valid, out_rnd, out_last, out_err, out_rk, out_data
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (FIPS-197 table).
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y_o = SBOX_TBL[a_i];

endmodule

// File: rtl/aes_round_pipe.sv
// One AES-128 encryption round with on-the-fly key expansion and valid/ready flow control.
// PIPE_MID=1 adds a register between ShiftRows and MixColumns.
module aes_round_pipe import aes_pkg::*; #(
    parameter int PIPE_MID = 1,
    parameter int RND_W    = 4
) (
    input logic            clk,
    input logic            rst,
    aes_round_pipe_if.slave bus
);

    logic [7:0]         sb [16];
    logic [7:0]         sw [4];
    logic [STATE_W-1:0] sr_d;
    logic [STATE_W-1:0] rk_d;
    logic               err_d;
    logic [31:0]        w0, w1, w2, w3, w4, w5, w6, w7, rot;

    for (genvar i = 0; i < 16; i++) begin : g_sb
        aes_sbox u_sb (.a_i(get_byte(bus.in_data, i)), .y_o(sb[i]));
    end

    // ShiftRows: row r of column c takes row r from column (c + r) mod 4
    for (genvar c = 0; c < 4; c++) begin : g_sr_col
        for (genvar r = 0; r < 4; r++) begin : g_sr_row
            assign sr_d[STATE_W-8-8*(4*c+r) +: 8] = sb[4*((c+r)%4)+r];
        end
    end

    assign w0  = get_word(bus.in_prev_rk, 0);
    assign w1  = get_word(bus.in_prev_rk, 1);
    assign w2  = get_word(bus.in_prev_rk, 2);
    assign w3  = get_word(bus.in_prev_rk, 3);
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_kb
        aes_sbox u_kb (.a_i(rot[8*(3-j) +: 8]), .y_o(sw[j]));
    end

    assign w4    = w0 ^ {sw[0], sw[1], sw[2], sw[3]} ^ {rcon(32'(bus.in_rnd)), 24'h0};
    assign w5    = w1 ^ w4;
    assign w6    = w2 ^ w5;
    assign w7    = w3 ^ w6;
    assign rk_d  = {w4, w5, w6, w7};
    assign err_d = !rnd_ok(32'(bus.in_rnd));

    logic               s2_in_valid;
    logic [STATE_W-1:0] s2_in_state;
    logic [STATE_W-1:0] s2_in_rk;
    logic [RND_W-1:0]   s2_in_rnd;
    logic               s2_in_last;
    logic               s2_in_err;
    logic               s2_ready;
    logic [STATE_W-1:0] s2_data_d;

    logic               s2_valid_q;
    logic [STATE_W-1:0] s2_data_q;
    logic [STATE_W-1:0] s2_rk_q;
    logic [RND_W-1:0]   s2_rnd_q;
    logic               s2_last_q;
    logic               s2_err_q;

    assign s2_ready = !s2_valid_q || bus.out_ready;

    if (PIPE_MID != 0) begin : g_mid
        logic               s1_ready;
        logic               s1_valid_q;
        logic [STATE_W-1:0] s1_state_q;
        logic [STATE_W-1:0] s1_rk_q;
        logic [RND_W-1:0]   s1_rnd_q;
        logic               s1_last_q;
        logic               s1_err_q;

        assign s1_ready = !s1_valid_q || s2_ready;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid_q <= 1'b0;
                s1_state_q <= '0;
                s1_rk_q    <= '0;
                s1_rnd_q   <= '0;
                s1_last_q  <= 1'b0;
                s1_err_q   <= 1'b0;
            end else if (s1_ready) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_state_q <= sr_d;
                    s1_rk_q    <= rk_d;
                    s1_rnd_q   <= bus.in_rnd;
                    s1_last_q  <= bus.in_last;
                    s1_err_q   <= err_d;
                end
            end
        end

        assign bus.in_ready = s1_ready;
        assign s2_in_valid  = s1_valid_q;
        assign s2_in_state  = s1_state_q;
        assign s2_in_rk     = s1_rk_q;
        assign s2_in_rnd    = s1_rnd_q;
        assign s2_in_last   = s1_last_q;
        assign s2_in_err    = s1_err_q;
    end else begin : g_flat
        assign bus.in_ready = s2_ready;
        assign s2_in_valid  = bus.in_valid;
        assign s2_in_state  = sr_d;
        assign s2_in_rk     = rk_d;
        assign s2_in_rnd    = bus.in_rnd;
        assign s2_in_last   = bus.in_last;
        assign s2_in_err    = err_d;
    end

    assign s2_data_d = (s2_in_last ? s2_in_state : mix_columns(s2_in_state)) ^ s2_in_rk;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_rk_q    <= '0;
            s2_rnd_q   <= '0;
            s2_last_q  <= 1'b0;
            s2_err_q   <= 1'b0;
        end else if (s2_ready) begin
            s2_valid_q <= s2_in_valid;
            if (s2_in_valid) begin
                s2_data_q <= s2_data_d;
                s2_rk_q   <= s2_in_rk;
                s2_rnd_q  <= s2_in_rnd;
                s2_last_q <= s2_in_last;
                s2_err_q  <= s2_in_err;
            end
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_rk    = s2_rk_q;
    assign bus.out_rnd   = s2_rnd_q;
    assign bus.out_last  = s2_last_q;
    assign bus.out_err   = s2_err_q;

endmodule

// File: doc/aes_round_pipe.md
Name: aes_round_pipe

Overview:
- Parametrised, handshaked AES-128 encryption round, the successor to the fixed four-stage round block.
- Datapath per round: SubBytes, ShiftRows, MixColumns (per-transaction bypass for the final round), AddRoundKey.
- On-the-fly key expansion derives the current round key from the previous one.
- Sits in the unrolled cipher chain, one instance per round. Valid/ready backpressure and optional mid-round pipelining allow timing closure per round.

Parameters:
- PIPE_MID, 1, 1 = register between ShiftRows and MixColumns; 0 = SB/SR/MC/ARK in one stage. Only 0 and 1 are legal.
- RND_W, 4, width of the round-index field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept the input this cycle
- in_rnd  in  RND_W  round number, 1..10; selects rcon
- in_last  in  1  final round; MixColumns is bypassed
- in_prev_rk  in  128  previous round key; for round 1 this is the cipher key
- in_data  in  128  round input state
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_rnd  out  RND_W  in_rnd carried through
- out_last  out  1  in_last carried through
- out_err  out  1  in_rnd was outside 1..10
- out_rk  out  128  current round key
- out_data  out  128  round output state

Behaviour:
- Byte order follows FIPS-197. Byte 0 = bits [127:120]. State is column-major: bytes 0-3 form column 0.
- Stage S1 (only when PIPE_MID=1):
  - Registers SubBytes+ShiftRows of in_data.
  - Registers the expanded key, rnd, last and err.
- Stage S2 (output register):
  - MixColumns, or bypass when last=1.
  - XOR with the current round key.
- Key expansion, combinational from in_prev_rk:
  - w4 = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w5 = w1^w4, w6 = w2^w5, w7 = w3^w6
- rcon for rnd 1..10: 01,02,04,08,10,20,40,80,1b,36.
- rnd outside 1..10: rcon=00, err=1. Data is still processed; the flag is informational only.
- Handshake:
  - A transfer occurs on valid&&ready.
  - Each stage holds a valid bit: stage_ready = !stage_valid || next_ready.
  - in_ready = S1 ready (PIPE_MID=1), or S2 ready (PIPE_MID=0).
  - in_ready must not depend combinationally on in_valid.
- Latency: accept to out_valid is PIPE_MID+1 cycles.
- Throughput: 1 transaction per clock when out_ready is held at 1.
- Stall: while out_valid && !out_ready, all out_* are held stable. S1, if present, holds when S2 is full and stalled.
- Simultaneous events: a full stage that is drained and refilled in the same cycle loads the new data with no bubble.
- Reset:
  - Clears all valid bits. out_valid=0; in_ready=1 in the cycle after reset deasserts.
  - out_data, out_rk, out_rnd, out_last and out_err reset to 0.
  - Reset mid-operation discards all in-flight transactions. No partial output appears.
- Arithmetic: xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0). All operations are 8-bit GF(2^8); there is no carry between bytes.

Decomposition:
- Package aes_pkg:
  - STATE_W=128
  - rcon lookup function
  - xtime and mix-column helper functions
  - byte/word extraction helpers
- Sub-module aes_sbox: combinational byte S-box, instantiated 20 times (16 for the state, 4 for SubWord).

Test Plan:
- FIPS-197 App. B round 1, out_ready=1:
  - in_data=193de3bea0f4e22b9ac68d2ae9f84808, in_prev_rk=2b7e151628aed2a6abf7158809cf4f3c, in_rnd=1, in_last=0
  - Required: out_data=a49c7ff2689f352b6b5bea43026a5049, out_rk=a0fafe1788542cb123a339392a6c7605, out_err=0
  - Required: out_valid exactly PIPE_MID+1 cycles after accept.
- Final round:
  - in_data=eb40f21e592e38848ba113e71bc342d2, in_prev_rk=ac7766f319fadc2128d12941575c006e, in_rnd=10, in_last=1
  - Required: out_rk=d014f9a8c9ee2589e13f0cc8b6630ca6, out_data=3925841d02dc09fbdc118597196a0b32
- Back-to-back plus backpressure:
  - Stimulus: stream both vectors above on consecutive cycles, then hold out_ready=0 for 5 cycles.
  - Required: in_ready falls once the pipeline is full; out_* stay stable during the stall.
  - Required: both results emerge in order with no loss or duplication; then 1 result per cycle resumes.
- Invalid round:
  - Stimulus: in_rnd=0, with the round-1 data and key.
  - Required: out_err=1; out_rk=w computed with rcon=00 (a0fafe17 ^ 01000000 in w4 → a1fafe17..., propagated through w5-w7).
- Reset mid-flight:
  - Stimulus: assert rst for 1 cycle with 2 transactions in flight.
  - Required: next cycle out_valid=0 and all out_* = 0; nothing emerges afterwards; a new transfer completes correctly.
- PIPE_MID=0 build: rerun test 1. Required: latency is 1 cycle and results are identical.
